// File: rtl/dm_cache_fsm_pkg.sv
// Shared cache types, field widths, controller states and line/word helpers.
package cache_def;

  localparam int TAGMSB = 31;
  localparam int TAGLSB = 14;

  typedef struct packed {
    logic                   valid;
    logic                   dirty;
    logic [TAGMSB-TAGLSB:0] tag;
  } cache_tag_type;

  typedef struct packed {
    logic [9:0] index;
    logic       we;
  } cache_req_type;

  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPARE    = 2'd1,
    WRITE_BACK = 2'd2,
    ALLOCATE   = 2'd3
  } cache_state_e;

  function automatic logic [31:0] get_word(input cache_data_type line, input logic [1:0] off);
    return line[{off, 5'd0} +: 32];
  endfunction

  function automatic cache_data_type put_word(input cache_data_type line, input logic [1:0] off,
                                              input logic [31:0] w);
    cache_data_type r;
    r = line;
    r[{off, 5'd0} +: 32] = w;
    return r;
  endfunction

endpackage

// File: rtl/dm_cache_fsm_if.sv
// CPU-side and memory-side buses of the cache controller.
interface dm_cache_fsm_if;
  import cache_def::*;

  cpu_req_type    cpu_req;
  cpu_result_type cpu_res;
  mem_req_type    mem_req;
  mem_data_type   mem_data;

  modport slave (input cpu_req, input mem_data, output cpu_res, output mem_req);
  modport master(output cpu_req, output mem_data, input cpu_res, input mem_req);
endinterface

// File: rtl/dm_cache_fsm.sv
// Direct-mapped write-back/write-allocate cache controller.
module dm_cache_fsm
  import cache_def::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  dm_cache_fsm_if.slave  bus,
  output cache_req_type  tag_req,
  output cache_tag_type  tag_write,
  input  cache_tag_type  tag_read,
  output cache_data_type data_write,
  input  cache_data_type data_read,
  output logic           data_we
);

  cache_state_e   r_state, w_state_d;
  logic           r_req_rw, w_req_rw_d;
  logic [31:2]    r_req_addr, w_req_addr_d;
  logic [31:0]    r_req_data, w_req_data_d;
  mem_req_type    r_mem_req, w_mem_req_d;
  cpu_result_type w_cpu_res;

  logic [17:0]    w_req_tag;
  logic [9:0]     w_req_idx;
  logic [1:0]     w_req_off;
  logic           w_hit;
  logic           w_unused_addr_lsb;

  assign w_req_tag = r_req_addr[TAGMSB:TAGLSB];
  assign w_req_idx = r_req_addr[13:4];
  assign w_req_off = r_req_addr[3:2];
  assign w_hit     = tag_read.valid && (tag_read.tag == w_req_tag);
  assign w_unused_addr_lsb = ^bus.cpu_req.addr[1:0];

  assign bus.mem_req = r_mem_req;
  assign bus.cpu_res = w_cpu_res;

  // State, request latch and registered memory request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_req_rw   <= 1'b0;
      r_req_addr <= '0;
      r_req_data <= '0;
      r_mem_req  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_req_rw   <= w_req_rw_d;
      r_req_addr <= w_req_addr_d;
      r_req_data <= w_req_data_d;
      r_mem_req  <= w_mem_req_d;
    end
  end

  // Next state, request capture and memory request sequencing
  always_comb begin
    w_state_d    = r_state;
    w_req_rw_d   = r_req_rw;
    w_req_addr_d = r_req_addr;
    w_req_data_d = r_req_data;
    w_mem_req_d  = r_mem_req;
    unique case (r_state)
      IDLE: begin
        if (bus.cpu_req.valid) begin
          w_req_rw_d   = bus.cpu_req.rw;
          w_req_addr_d = bus.cpu_req.addr[31:2];
          w_req_data_d = bus.cpu_req.data;
          w_state_d    = COMPARE;
        end
      end
      COMPARE: begin
        if (w_hit) begin
          w_state_d = IDLE;
        end else if (tag_read.valid && tag_read.dirty) begin
          w_mem_req_d.addr  = {tag_read.tag, w_req_idx, 4'h0};
          w_mem_req_d.data  = data_read;
          w_mem_req_d.rw    = 1'b1;
          w_mem_req_d.valid = 1'b1;
          w_state_d         = WRITE_BACK;
        end else begin
          w_mem_req_d.addr  = {w_req_tag, w_req_idx, 4'h0};
          w_mem_req_d.rw    = 1'b0;
          w_mem_req_d.valid = 1'b1;
          w_state_d         = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        // valid stays high: the refill read follows the write-back back to back
        if (bus.mem_data.ready) begin
          w_mem_req_d.addr = {w_req_tag, w_req_idx, 4'h0};
          w_mem_req_d.rw   = 1'b0;
          w_state_d        = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (bus.mem_data.ready) begin
          w_mem_req_d.valid = 1'b0;
          w_state_d         = COMPARE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // CPU response and tag/data memory controls
  always_comb begin
    w_cpu_res      = '0;
    tag_req.index  = w_req_idx;
    tag_req.we     = 1'b0;
    tag_write      = '{valid: 1'b1, dirty: 1'b0, tag: w_req_tag};
    data_write     = data_read;
    data_we        = 1'b0;
    unique case (r_state)
      COMPARE: begin
        if (w_hit) begin
          w_cpu_res.data  = get_word(data_read, w_req_off);
          w_cpu_res.ready = 1'b1;
          if (r_req_rw) begin
            data_write      = put_word(data_read, w_req_off, r_req_data);
            data_we         = 1'b1;
            tag_write.dirty = 1'b1;
            tag_req.we      = 1'b1;
          end
        end
      end
      ALLOCATE: begin
        if (bus.mem_data.ready) begin
          data_write = bus.mem_data.data;
          data_we    = 1'b1;
          tag_req.we = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/dm_cache_fsm.md
Name: dm_cache_fsm

Overview:
- Controller for the direct-mapped, write-back, write-allocate cache.
- Accepts one CPU word request at a time and looks it up in the tag and data memories, which are combinational-read and write on the clock edge.
- On a miss it writes back a dirty victim line, refills the line from main memory, then replays the lookup.
- Instantiated beside dm_cache_tag and dm_cache_data inside dm_cache_top.

Parameters:
- None. Widths are fixed by cache_def: 32-bit address; tag = addr[31:14] (18b); index = addr[13:4] (10b, 1024 lines); word offset = addr[3:2]; 128-bit line; 32-bit word.

Ports:
- clk_i  in  1  single clock; all state changes on posedge.
- rst_ni  in  1  reset, asynchronous, active-low.
- cpu_req  in  66  {valid, rw(1=write), addr[31:0], data[31:0]}.
- cpu_res  out  33  {data[31:0], ready}.
- mem_req  out  162  {addr[31:0], data[127:0], rw, valid}.
- mem_data  in  129  {data[127:0], ready}.
- tag_req  out  11  {index[9:0], we}, shared by tag and data memories.
- tag_write  out  20  {valid, dirty, tag[17:0]}.
- tag_read  in  20  current tag entry at tag_req.index.
- data_write  out  128  line to write.
- data_read  in  128  current line at tag_req.index.
- data_we  out  1  data memory write enable.

Behaviour:
- States: IDLE, COMPARE, WRITE_BACK, ALLOCATE (enum cache_state_e).
- Reset (async assert):
  - state=IDLE.
  - cpu_res.ready=0, cpu_res.data=0.
  - mem_req.valid=0, mem_req.rw=0, mem_req.addr=0, mem_req.data=0.
  - tag_req.we=0, data_we=0.
  - Request latch cleared.
- Reset mid-miss abandons the memory transaction, drops the request and leaves tag/data contents untouched. The memory side must tolerate a dropped valid.
- IDLE:
  - If cpu_req.valid is high at posedge, latch rw/addr/data into req_q and go to COMPARE.
  - cpu_req is sampled only in IDLE and ignored in all other states.
- COMPARE:
  - tag_req.index=req_q index.
  - hit = tag_read.valid && tag_read.tag == req_q tag.
  - Read hit: cpu_res.data = word[offset] of data_read; cpu_res.ready=1 this cycle (combinational); next state IDLE.
  - Write hit: data_write = data_read with word[offset] replaced by req_q.data; data_we=1; tag_write={1,1,tag}; tag_req.we=1; ready=1; next state IDLE.
  - Miss with victim clean or invalid: load mem_req {addr={req tag,index,4'h0}, rw=0, valid=1}; next state ALLOCATE.
  - Miss with victim valid and dirty: load mem_req {addr={tag_read.tag,index,4'h0}, data=data_read, rw=1, valid=1}; next state WRITE_BACK.
- WRITE_BACK:
  - Hold mem_req stable until mem_data.ready.
  - On ready, the next edge loads the refill read (rw=0, new addr; valid stays 1); next state ALLOCATE.
- ALLOCATE:
  - Hold the read until mem_data.ready.
  - On ready, the same cycle drives data_write=mem_data.data, data_we=1, tag_write={1,0,req tag}, tag_req.we=1.
  - Next edge: mem_req.valid=0; next state COMPARE. The replay then hits.
- mem_data.ready outside WRITE_BACK/ALLOCATE is ignored.
- Outputs mem_req.* are registered. cpu_res, tag_req, tag_write, data_write and data_we are combinational from state, req_q and memory reads.
- Latency (T0 = request sampled):
  - Hit: ready at T1.
  - Clean miss with memory latency L: ready at T3+L.
  - Dirty miss with write latency Lw and read latency Lr: ready at T4+Lw+Lr.
- The CPU holds its request until ready and must drop valid in the cycle after ready unless issuing a new request.
- Write miss: allocate, then the COMPARE write-hit path merges the word and sets dirty. Hitting an already-dirty line keeps it dirty.

Decomposition:
- cache_def holds:
  - cpu_req_type, cpu_result_type, mem_req_type, mem_data_type, cache_data_type, cache_tag_type, cache_req_type.
  - cache_state_e.
  - TAGMSB=31, TAGLSB=14.
- No internal sub-module. dm_cache_top is the natural wrapper instantiating dm_cache_fsm, dm_cache_tag and dm_cache_data.

Test Plan:
- Cold read 0x0000_0010, memory returns 128'h4444_3333_2222_1111 after 3 cycles -> mem read addr 0x10 issued; ready at T6 with data 0x1111_2222? no: word0=32'h2222_1111; tag[1]={1,0,0}.
- Read hit 0x0000_0014 after the fill -> ready at T1, data=32'h4444_3333? no: word1=32'h4444_3333; no mem_req.valid.
- Write 0x0000_0018 data 0xDEAD_BEEF on a resident line -> ready T1; line word2=DEADBEEF; tag[1].dirty=1.
- Read 0x0000_4010 (same index, tag 1) with line 1 dirty -> write-back to 0x10 with the modified line, then read of 0x4010; tag becomes {1,0,18'h1}.
- Write miss to 0x0000_8020 -> allocate read of 0x8020, then merge; tag[2]={1,1,18'h2}.
- rst_ni low while in ALLOCATE -> mem_req.valid=0 immediately, state IDLE, cpu_res.ready=0; a new request after reset completes normally.
